control_multiciclo: RTL and testbench

CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

---
 rtl/control_multiciclo_if.sv | 38 +++
 rtl/control_multiciclo.sv | 197 +++++++++++++++++++
 tb/tb_control_multiciclo.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_multiciclo_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The signal names keep the controller's point of view (_i into the
// controller, _o out of it) so both sides read the same.
//   master : the controller (control_multiciclo)
//   slave  : the datapath / memory side that drives run, IR and ready
interface control_multiciclo_if;
  logic        run_i;
  logic [31:0] instruccion_i;
  logic        mem_ready_i;

  logic [2:0]  state_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        addr_sel_o;
  logic        ir_we_o;
  logic        pc_we_o;
  logic [1:0]  imm_sel_o;
  logic        alu_src_o;
  logic [1:0]  alu_op_o;
  logic        rf_we_o;
  logic        wb_sel_o;
  logic        illegal_o;
  logic        bus_err_o;

  modport master (
    input  run_i, instruccion_i, mem_ready_i,
    output state_o, mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o,
           imm_sel_o, alu_src_o, alu_op_o, rf_we_o, wb_sel_o,
           illegal_o, bus_err_o
  );

  modport slave (
    output run_i, instruccion_i, mem_ready_i,
    input  state_o, mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o,
           imm_sel_o, alu_src_o, alu_op_o, rf_we_o, wb_sel_o,
           illegal_o, bus_err_o
  );
endinterface

// File: rtl/control_multiciclo.sv
// Multicycle RISC-V style control unit (R, I, load, store).
// Sequence: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH/IDLE.
// Outputs are decoded from the registered state, the current opcode and
// mem_ready_i (ready-qualified strobes only).
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   ctrl         control_multiciclo_if.master (run, IR, mem handshake and
//                all datapath strobes, state_o, illegal_o, bus_err_o)
//   instr_cnt_o  retired-instruction counter, only with CTRL_INSTR_COUNT_EN
//
// Parameter MEM_TIMEOUT (1..255): wait cycles in FETCH/MEM without
// mem_ready_i before a bus error parks the FSM in HALT.
//
// Optional feature macro: CTRL_INSTR_COUNT_EN adds instr_cnt_o.
module control_multiciclo #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  control_multiciclo_if.master ctrl
`ifdef CTRL_INSTR_COUNT_EN
  ,
  output logic [31:0]          instr_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;

  logic [6:0]  opcode;
  logic        is_r, is_i, is_ld, is_st, legal;
  logic [1:0]  imm_dec;
  logic        wait_expired;
  logic        unused_instr;

  logic        mem_req, mem_we, addr_sel, ir_we, pc_we;
  logic [1:0]  imm_sel, alu_op;
  logic        alu_src, rf_we, wb_sel, illegal, bus_err;

  assign opcode  = ctrl.instruccion_i[6:0];
  assign is_r    = (opcode == OP_R);
  assign is_i    = (opcode == OP_I);
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign legal   = is_r | is_i | is_ld | is_st;
  assign imm_dec = (is_i | is_ld) ? 2'b01 : (is_st ? 2'b10 : 2'b00);

  // Only the opcode field steers control.
  assign unused_instr = ^ctrl.instruccion_i[31:7];

  // This cycle would be the MEM_TIMEOUT-th consecutive one without ready.
  assign wait_expired = ((wait_q + 8'd1) == TIMEOUT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    imm_sel  = 2'b00;
    alu_src  = 1'b0;
    alu_op   = 2'b00;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    illegal  = 1'b0;
    bus_err  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl.run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (ctrl.mem_ready_i) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          bus_err = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        imm_sel = imm_dec;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          // Skip the bad word: bump PC and carry on.
          illegal = 1'b1;
          pc_we   = 1'b1;
          state_d = ctrl.run_i ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC: begin
        imm_sel = imm_dec;
        alu_src = ~is_r;
        alu_op  = (is_ld | is_st) ? 2'b00 : 2'b10;
        state_d = (is_ld | is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        imm_sel  = imm_dec;
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_st;
        if (ctrl.mem_ready_i) begin
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = ctrl.run_i ? S_FETCH : S_IDLE;
          end
        end else if (wait_expired) begin
          bus_err = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        imm_sel = imm_dec;
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        wb_sel  = is_ld;
        state_d = ctrl.run_i ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        // Parked until reset.
      end
      default: state_d = S_IDLE;
    endcase

    // Fresh wait budget whenever a new state is entered.
    if (state_d != state_q) wait_d = '0;
  end

  assign ctrl.state_o    = state_q;
  assign ctrl.mem_req_o  = mem_req;
  assign ctrl.mem_we_o   = mem_we;
  assign ctrl.addr_sel_o = addr_sel;
  assign ctrl.ir_we_o    = ir_we;
  assign ctrl.pc_we_o    = pc_we;
  assign ctrl.imm_sel_o  = imm_sel;
  assign ctrl.alu_src_o  = alu_src;
  assign ctrl.alu_op_o   = alu_op;
  assign ctrl.rf_we_o    = rf_we;
  assign ctrl.wb_sel_o   = wb_sel;
  assign ctrl.illegal_o  = illegal;
  assign ctrl.bus_err_o  = bus_err;

`ifdef CTRL_INSTR_COUNT_EN
  logic        retire;
  logic [31:0] icnt_q;

  // Retire points: WB exit, or store completion in MEM.
  assign retire = (state_q == S_WB) |
                  ((state_q == S_MEM) & ctrl.mem_ready_i & ~is_ld);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     icnt_q <= '0;
    else if (retire) icnt_q <= icnt_q + 32'd1;
  end

  assign instr_cnt_o = icnt_q;
`endif

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench for control_multiciclo. A per-instruction schedule
// builder turns (instruction, fetch waits, mem waits, run at retire) into the
// cycle-by-cycle inputs and required outputs; a driver replays the schedule
// and a compare process checks every cycle. Literal checks pin the builder.
module tb_control_multiciclo;
  localparam int TO = 15;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  control_multiciclo_if bus();
`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] instr_cnt_o;
`endif

  control_multiciclo #(.MEM_TIMEOUT(TO)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ctrl  (bus)
`ifdef CTRL_INSTR_COUNT_EN
    ,
    .instr_cnt_o(instr_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq, mwe, asel, irwe, pcwe;
    logic [1:0] imm;
    logic       asrc;
    logic [1:0] aop;
    logic       rfwe, wbsel, ill, berr;
  } out_t;

  typedef struct {
    logic        rst_n;
    logic        run;
    logic        rdy;
    logic [31:0] ins;
    logic        preload;
    out_t        e;
    logic [31:0] cnt;
  } cyc_t;

  cyc_t        sched[$];
  cyc_t        expq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mcnt = 0;
  logic [31:0] cur_ins = 0;
  logic        pend_preload = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic rb();
    return ($urandom_range(0, 1) != 0);
  endfunction

  function automatic out_t st_only(input logic [2:0] s);
    out_t o;
    o = '0;
    o.st = s;
    return o;
  endfunction

  task automatic push(input logic run, input logic rdy, input out_t e, input bit retire);
    cyc_t c;
    c.rst_n = 1'b1; c.run = run; c.rdy = rdy; c.ins = cur_ins;
    c.preload = pend_preload; c.e = e; c.cnt = mcnt;
    pend_preload = 1'b0;
    sched.push_back(c);
    if (retire) mcnt = mcnt + 32'd1;
  endtask

  task automatic push_reset();
    cyc_t c;
    mcnt = 0;
    c.rst_n = 1'b0; c.run = rb(); c.rdy = rb(); c.ins = cur_ins;
    c.preload = 1'b0; c.e = '0; c.cnt = 0;
    sched.push_back(c);
  endtask

  // n idle cycles with run low, then one with run high (leaves for FETCH).
  task automatic idle_go(input int n);
    for (int k = 0; k < n; k++) push(1'b0, rb(), st_only(3'd0), 0);
    push(1'b1, rb(), st_only(3'd0), 0);
  endtask

  task automatic fetch_waits(input int n);
    out_t e;
    for (int k = 0; k < n; k++) begin
      e = st_only(3'd1); e.mreq = 1'b1;
      push(rb(), 1'b0, e, 0);
    end
  endtask

  // One instruction from FETCH entry to its retire/abort point.
  task automatic add_instr(input logic [31:0] ins, input int wf, input int wm,
                           input logic run_last, input bit mem_to);
    logic [6:0] op;
    bit r, i, l, s, x;
    logic [1:0] imm;
    out_t e;
    op = ins[6:0];
    r = (op == 7'h33); i = (op == 7'h13); l = (op == 7'h03); s = (op == 7'h23);
    x = !(r || i || l || s);
    imm = (i || l) ? 2'b01 : (s ? 2'b10 : 2'b00);
    cur_ins = ins;
    fetch_waits(wf);
    e = st_only(3'd1); e.mreq = 1'b1; e.irwe = 1'b1;
    push(rb(), 1'b1, e, 0);
    e = st_only(3'd2); e.imm = imm;
    if (x) begin
      e.ill = 1'b1; e.pcwe = 1'b1;
      push(run_last, rb(), e, 0);
    end else begin
      push(rb(), rb(), e, 0);
      e = st_only(3'd3); e.imm = imm; e.asrc = !r; e.aop = (l || s) ? 2'b00 : 2'b10;
      push(rb(), rb(), e, 0);
      if (l || s) begin
        e = st_only(3'd4); e.imm = imm; e.mreq = 1'b1; e.asel = 1'b1; e.mwe = s;
        if (mem_to) begin
          for (int k = 0; k < TO - 1; k++) push(rb(), 1'b0, e, 0);
          e.berr = 1'b1;
          push(rb(), 1'b0, e, 0);
          for (int k = 0; k < 3; k++) push(rb(), rb(), st_only(3'd6), 0);
          push_reset();
          return;
        end
        for (int k = 0; k < wm; k++) push(rb(), 1'b0, e, 0);
        if (s) begin
          e.pcwe = 1'b1;
          push(run_last, 1'b1, e, 1);
        end else begin
          push(rb(), 1'b1, e, 0);
        end
      end
      if (!s) begin
        e = st_only(3'd5); e.imm = imm; e.rfwe = 1'b1; e.pcwe = 1'b1; e.wbsel = l;
        push(run_last, rb(), e, 1);
      end
    end
    if (!run_last) idle_go($urandom_range(0, 2));
  endtask

  task automatic add_fetch_timeout();
    out_t e;
    cur_ins = $urandom;
    fetch_waits(TO - 1);
    e = st_only(3'd1); e.mreq = 1'b1; e.berr = 1'b1;
    push(rb(), 1'b0, e, 0);
    for (int k = 0; k < 4; k++) push(1'b1, rb(), st_only(3'd6), 0);
    push_reset();
  endtask

  function automatic logic [31:0] rand_instr(input int kind);
    logic [31:0] w;
    logic [6:0] op;
    w = $urandom;
    case (kind)
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h03;
      3: op = 7'h23;
      default: begin
        op = 7'($urandom_range(0, 127));
        while (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23)
          op = 7'($urandom_range(0, 127));
      end
    endcase
    w[6:0] = op;
    return w;
  endfunction

  // Compare process: every scheduled cycle, mid-cycle.
  cyc_t cmp_c;
  out_t cmp_got;
  always @(negedge clk_i) begin
    if (expq.size() != 0) begin
      cmp_c = expq.pop_front();
      cmp_got = {bus.state_o, bus.mem_req_o, bus.mem_we_o, bus.addr_sel_o,
                 bus.ir_we_o, bus.pc_we_o, bus.imm_sel_o, bus.alu_src_o,
                 bus.alu_op_o, bus.rf_we_o, bus.wb_sel_o, bus.illegal_o,
                 bus.bus_err_o};
      chk("outputs", 32'(cmp_got), 32'(cmp_c.e));
`ifdef CTRL_INSTR_COUNT_EN
      chk("instr_cnt", instr_cnt_o, cmp_c.cnt);
`endif
    end
  end

  int s_addi, s_lw, s_sw, s_ill, s_fto, s_pre, nrf, nmem;
  bit forced;

  initial begin
    bus.run_i = 1'b0; bus.instruccion_i = '0; bus.mem_ready_i = 1'b0;
    forced = 1'b0;

    // ---- directed schedule ----
    push_reset();
    idle_go(2);
    s_addi = sched.size(); add_instr(32'h00500093, 0, 0, 1'b1, 0);
    s_lw   = sched.size(); add_instr(32'h0000A103, 0, 3, 1'b1, 0);
    s_sw   = sched.size(); add_instr(32'h0020A023, 0, 0, 1'b1, 0);
    s_ill  = sched.size(); add_instr(32'h0000007F, 0, 0, 1'b0, 0);
    add_instr(32'h002081B3, TO - 1, 0, 1'b1, 0);   // ready on the last allowed cycle
    add_instr(32'h0040A183, 1, TO - 1, 1'b1, 0);
    add_instr(32'h0030A223, 2, 1, 1'b0, 0);
    // reset while a fetch is outstanding
    cur_ins = 32'h00100093;
    fetch_waits(2);
    push_reset();
    idle_go(1);
    s_fto = sched.size(); add_fetch_timeout();
    mcnt = 32'hFFFFFFFF;
    pend_preload = 1'b1;
    idle_go(1);
    s_pre = sched.size(); add_instr(32'h00500093, 0, 0, 1'b1, 0);
    add_instr(32'h0000A103, 1, 0, 1'b1, 1);         // MEM timeout
    idle_go(1);

    // ---- random schedule ----
    for (int n = 0; n < 250; n++) begin
      int kind, wf, wm;
      kind = $urandom_range(0, 4);
      wf = ($urandom_range(0, 15) == 0) ? TO - 1 : $urandom_range(0, 3);
      wm = ($urandom_range(0, 15) == 0) ? TO - 1 : $urandom_range(0, 3);
      add_instr(rand_instr(kind), wf, wm, $urandom_range(0, 3) != 0, 0);
    end

    // ---- pin the schedule builder with hand-derived values ----
    chk("addi_st0", 32'(sched[s_addi + 0].e.st), 1);
    chk("addi_st1", 32'(sched[s_addi + 1].e.st), 2);
    chk("addi_st2", 32'(sched[s_addi + 2].e.st), 3);
    chk("addi_st3", 32'(sched[s_addi + 3].e.st), 5);
    chk("addi_st4", 32'(sched[s_addi + 4].e.st), 1);
    chk("addi_imm", 32'(sched[s_addi + 1].e.imm), 1);
    chk("addi_asrc", 32'(sched[s_addi + 2].e.asrc), 1);
    nrf = 0;
    for (int k = 0; k < 4; k++) nrf += int'(sched[s_addi + k].e.rfwe);
    chk("addi_rfwe_cycles", 32'(nrf), 1);
    chk("lw_len", 32'(s_sw - s_lw), 8);
    nmem = 0;
    for (int k = s_lw; k < s_sw; k++) nmem += (sched[k].e.st == 3'd4) ? 1 : 0;
    chk("lw_mem_cycles", 32'(nmem), 4);
    chk("lw_wbsel", 32'(sched[s_lw + 7].e.wbsel), 1);
    chk("sw_len", 32'(s_ill - s_sw), 4);
    chk("sw_mem", 32'({sched[s_sw + 3].e.mwe, sched[s_sw + 3].e.asel,
                       sched[s_sw + 3].e.imm, sched[s_sw + 3].e.pcwe}), 32'b11101);
    nrf = 0;
    for (int k = 0; k < 4; k++) nrf += int'(sched[s_sw + k].e.rfwe);
    chk("sw_rfwe_cycles", 32'(nrf), 0);
    chk("ill_pulse", 32'({sched[s_ill + 1].e.ill, sched[s_ill + 1].e.pcwe}), 3);
    chk("ill_no_exec", 32'(sched[s_ill + 2].e.st), 0);
    chk("fto_berr13", 32'(sched[s_fto + 13].e.berr), 0);
    chk("fto_berr14", 32'(sched[s_fto + 14].e.berr), 1);
    chk("fto_halt", 32'(sched[s_fto + 15].e.st), 6);
    chk("pre_cnt_before", sched[s_pre + 3].cnt, 32'hFFFFFFFF);
    chk("pre_cnt_wrap", sched[s_pre + 4].cnt, 32'h0);

    // ---- replay against the DUT ----
    for (int n = 0; n < sched.size(); n++) begin
      @(posedge clk_i);
      #1;
`ifdef CTRL_INSTR_COUNT_EN
      if (forced) begin
        release dut.icnt_q;
        forced = 1'b0;
      end
`endif
      rst_ni             = sched[n].rst_n;
      bus.run_i          = sched[n].run;
      bus.instruccion_i  = sched[n].ins;
      bus.mem_ready_i    = sched[n].rdy;
`ifdef CTRL_INSTR_COUNT_EN
      if (sched[n].preload) begin
        force dut.icnt_q = 32'hFFFFFFFF;
        forced = 1'b1;
      end
`endif
      expq.push_back(sched[n]);
      if (!sched[n].rst_n) begin
        #1;
        chk("rst_async_state", 32'(bus.state_o), 0);
        chk("rst_async_req", 32'(bus.mem_req_o), 0);
      end
    end
    @(negedge clk_i);
    #1;
    chk("schedule_drained", 32'(expq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
